rib_master_arbiter: RTL and testbench

- Registered round-robin arbiter that shares the RIB bus between its four masters: core data port, core fetch, JTAG and UART download.
- Converts the per-master request lines into a one-hot grant, a grant index, and per-master stall flags.
- Supports locked multi-cycle ownership with a bounded hold time, so no master can starve another.
- Sits between the masters and the RIB address/data mux; the mux steers by grant_id_o when grant_valid_o=1.

---
 rtl/rib_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rib_master_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_master_arbiter.sv
// Registered round-robin arbiter sharing the RIB bus among four masters
// (core data, core fetch, JTAG, UART download) with bounded locked ownership.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_i          per-master level request, held until served
//   lock_i         per-master lock, sampled only while that master owns the bus
//   grant_o        registered one-hot grant
//   grant_id_o     registered owner index, 0 when idle
//   grant_valid_o  registered, 1 whenever grant_o is non-zero
//   hold_o         per-master stall, req_i & ~grant_o (combinational)
//   core_hold_o    stall for the core pipeline, hold_o[0] | hold_o[1]
module rib_master_arbiter #(
    parameter int NUM_M    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_i,
    input  logic [NUM_M-1:0] lock_i,
    output logic [NUM_M-1:0] grant_o,
    output logic [1:0]       grant_id_o,
    output logic             grant_valid_o,
    output logic [NUM_M-1:0] hold_o,
    output logic             core_hold_o
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       rr_ptr_q;
    logic [1:0]       rr_ptr_d;
    logic [HW-1:0]    hold_cnt_q;
    logic [HW-1:0]    hold_cnt_d;
    logic [NUM_M-1:0] grant_q;
    logic [NUM_M-1:0] grant_d;
    logic [1:0]       grant_id_q;
    logic [1:0]       grant_id_d;
    logic             grant_valid_q;
    logic             grant_valid_d;

    logic [1:0]       winner;
    logic             any_req;
    logic             others;
    logic             owner_req;
    logic             owner_lock;
    logic             hold_ok;
    logic             keep;

    // Circular scan starting at rr_ptr. Because rr_ptr sits just past the
    // previous winner, that winner is searched last and only wins again
    // when nobody else is asking.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx    = '0;
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int i = 0; i < NUM_M; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // grant_q is one-hot of the owner while in GRANT, so masking with it
    // isolates the owner's own request and lock bits.
    assign any_req    = |req_i;
    assign others     = |(req_i & ~grant_q);
    assign owner_req  = |(req_i & grant_q);
    assign owner_lock = |(lock_i & grant_q);
    assign hold_ok    = (hold_cnt_q < HOLD_LAST);
    assign keep       = owner_req & (~others | (owner_lock & hold_ok));

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d         = GRANT;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    grant_valid_d   = 1'b1;
                    rr_ptr_d        = winner + 2'd1;
                    hold_cnt_d      = '0;
                end
            end
            GRANT: begin
                if (keep) begin
                    // Saturates so a long sole owner releases on the first
                    // cycle a competitor appears.
                    if (hold_ok) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else if (any_req) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    grant_valid_d   = 1'b1;
                    rr_ptr_d        = winner + 2'd1;
                    hold_cnt_d      = '0;
                end else begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = grant_id_q;
    assign grant_valid_o = grant_valid_q;
    assign hold_o        = req_i & ~grant_q;
    assign core_hold_o   = hold_o[0] | hold_o[1];

endmodule

// File: tb/tb_rib_master_arbiter.sv
// Self-checking bench for rib_master_arbiter: directed scenarios plus a
// randomized run against a cycle-level ownership model.
module tb_rib_master_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [3:0] grant_o;
    logic [1:0] grant_id_o;
    logic       grant_valid_o;
    logic [3:0] hold_o;
    logic       core_hold_o;

    int n_vec;
    int n_err;

    // Reference model: who owns the bus, where the next search starts,
    // and how many consecutive cycles the owner has had it.
    int         owner;
    int         ptr;
    int         held;
    logic [3:0] exp_g;
    logic [1:0] exp_id;

    rib_master_arbiter #(
        .NUM_M    (4),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .lock_i        (lock_i),
        .grant_o       (grant_o),
        .grant_id_o    (grant_id_o),
        .grant_valid_o (grant_valid_o),
        .hold_o        (hold_o),
        .core_hold_o   (core_hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step(input logic x, input logic [3:0] r,
                                       input logic [3:0] l);
        logic [3:0] oth;
        if (x) begin
            owner = -1;
            ptr   = 0;
            held  = 0;
        end else begin
            oth = (owner >= 0) ? (r & ~(4'b1 << owner)) : r;
            if (owner >= 0 && r[owner] &&
                (oth == 4'b0 || (l[owner] && held < MAX_HOLD))) begin
                held = held + 1;
            end else if (r != 4'b0) begin
                owner = -1;
                for (int i = 0; i < 4; i++) begin
                    if (owner < 0 && r[(ptr + i) % 4]) owner = (ptr + i) % 4;
                end
                ptr  = (owner + 1) % 4;
                held = 1;
            end else begin
                owner = -1;
                held  = 0;
            end
        end
        exp_g  = (owner < 0) ? 4'b0 : 4'(1 << owner);
        exp_id = (owner < 0) ? 2'd0 : 2'(owner);
    endfunction

    // Drive one cycle's inputs, let the edge happen, advance the model,
    // then leave time 1 unit past the edge for the caller to sample.
    task automatic tick(input logic [3:0] r, input logic [3:0] l,
                        input logic x);
        req_i  = r;
        lock_i = l;
        rst    = x;
        @(posedge clk);
        model_step(x, r, l);
        #1;
    endtask

    task automatic test_reset;
        tick(4'b1111, 4'b0000, 1'b1);
        tick(4'b1111, 4'b0000, 1'b1);
        n_vec++;
        if (grant_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_grant got=%b exp=0000", grant_o);
        end
        n_vec++;
        if (grant_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid got=%b exp=0", grant_valid_o);
        end
        n_vec++;
        if (grant_id_o !== 2'd0) begin
            n_err++;
            $display("FAIL rst_id got=%0d exp=0", grant_id_o);
        end
        n_vec++;
        if (hold_o !== 4'b1111) begin
            n_err++;
            $display("FAIL rst_hold got=%b exp=1111", hold_o);
        end
        n_vec++;
        if (core_hold_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_core_hold got=%b exp=1", core_hold_o);
        end
        tick(4'b1111, 4'b0000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0001 || grant_o !== exp_g) begin
            n_err++;
            $display("FAIL rst_first got=%b exp=0001", grant_o);
        end
    endtask

    task automatic test_rotation;
        logic [3:0] e;
        tick(4'b0000, 4'b0000, 1'b0);
        n_vec++;
        if (grant_valid_o !== 1'b0 || grant_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rot_idle got=%b/%b exp=0/0000",
                     grant_valid_o, grant_o);
        end
        for (int i = 0; i < 6; i++) begin
            tick(4'b0110, 4'b0000, 1'b0);
            e = (i % 2 == 0) ? 4'b0010 : 4'b0100;
            n_vec++;
            if (grant_o !== e || grant_o !== exp_g) begin
                n_err++;
                $display("FAIL rot_grant cyc=%0d got=%b exp=%b", i, grant_o, e);
            end
            n_vec++;
            if (grant_id_o !== exp_id) begin
                n_err++;
                $display("FAIL rot_id cyc=%0d got=%0d exp=%0d",
                         i, grant_id_o, exp_id);
            end
            n_vec++;
            if (hold_o !== (4'b0110 & ~e)) begin
                n_err++;
                $display("FAIL rot_hold cyc=%0d got=%b exp=%b",
                         i, hold_o, 4'b0110 & ~e);
            end
        end
    endtask

    task automatic test_lock_limit;
        logic [3:0] e;
        tick(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 2 * MAX_HOLD + 1; i++) begin
            tick(4'b0011, 4'b0001, 1'b0);
            e = (i == MAX_HOLD) ? 4'b0010 : 4'b0001;
            n_vec++;
            if (grant_o !== e || grant_o !== exp_g) begin
                n_err++;
                $display("FAIL lock_grant cyc=%0d got=%b exp=%b", i, grant_o, e);
            end
        end
    endtask

    task automatic test_sole_lock;
        tick(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(4'b1000, 4'b1000, 1'b0);
            n_vec++;
            if (grant_o !== 4'b1000 || grant_id_o !== 2'd3) begin
                n_err++;
                $display("FAIL sole_grant cyc=%0d got=%b/%0d exp=1000/3",
                         i, grant_o, grant_id_o);
            end
        end
        tick(4'b1001, 4'b1000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0001 || grant_o !== exp_g) begin
            n_err++;
            $display("FAIL sole_release got=%b exp=0001", grant_o);
        end
    endtask

    task automatic test_release_idle;
        tick(4'b0100, 4'b0000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0100 || grant_id_o !== 2'd2) begin
            n_err++;
            $display("FAIL rel_m2 got=%b/%0d exp=0100/2", grant_o, grant_id_o);
        end
        tick(4'b0000, 4'b0000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rel_idle got=%b/%b exp=0000/0",
                     grant_o, grant_valid_o);
        end
        tick(4'b0101, 4'b0000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0001 || grant_o !== exp_g) begin
            n_err++;
            $display("FAIL rel_rereq got=%b exp=0001", grant_o);
        end
    endtask

    task automatic test_mid_reset;
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b1000, 4'b1000, 1'b0);
        tick(4'b1001, 4'b1000, 1'b0);
        tick(4'b1001, 4'b1000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b1000) begin
            n_err++;
            $display("FAIL mrst_owner got=%b exp=1000", grant_o);
        end
        tick(4'b1001, 4'b1000, 1'b1);
        n_vec++;
        if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_drop got=%b/%b exp=0000/0",
                     grant_o, grant_valid_o);
        end
        tick(4'b1001, 4'b0000, 1'b0);
        n_vec++;
        if (grant_o !== 4'b0001 || grant_o !== exp_g) begin
            n_err++;
            $display("FAIL mrst_first got=%b exp=0001", grant_o);
        end
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [3:0] l;
        logic       x;
        int         wt[4];
        r = 4'b0000;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
                else if (exp_g[i] && $urandom_range(0, 2) == 0) r[i] = 1'b0;
            end
            l = 4'($urandom);
            x = ($urandom_range(0, 99) == 0);
            tick(r, l, x);
            n_vec++;
            if (grant_o !== exp_g) begin
                n_err++;
                $display("FAIL rnd_grant cyc=%0d got=%b exp=%b",
                         c, grant_o, exp_g);
            end
            n_vec++;
            if (grant_id_o !== exp_id) begin
                n_err++;
                $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d",
                         c, grant_id_o, exp_id);
            end
            n_vec++;
            if (grant_valid_o !== (exp_g != 4'b0)) begin
                n_err++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b",
                         c, grant_valid_o, exp_g != 4'b0);
            end
            n_vec++;
            if (hold_o !== (r & ~exp_g)) begin
                n_err++;
                $display("FAIL rnd_hold cyc=%0d got=%b exp=%b",
                         c, hold_o, r & ~exp_g);
            end
            n_vec++;
            if (core_hold_o !== ((r[0] & ~exp_g[0]) | (r[1] & ~exp_g[1]))) begin
                n_err++;
                $display("FAIL rnd_core_hold cyc=%0d got=%b", c, core_hold_o);
            end
            for (int i = 0; i < 4; i++) begin
                if (x || !r[i] || exp_g[i]) wt[i] = 0;
                else wt[i] = wt[i] + 1;
                n_vec++;
                if (wt[i] > 3 * MAX_HOLD) begin
                    n_err++;
                    $display("FAIL rnd_starve cyc=%0d m=%0d wait=%0d max=%0d",
                             c, i, wt[i], 3 * MAX_HOLD);
                    wt[i] = 0;
                end
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        owner  = -1;
        ptr    = 0;
        held   = 0;
        exp_g  = 4'b0;
        exp_id = 2'd0;
        rst    = 1'b1;
        req_i  = 4'b0;
        lock_i = 4'b0;
        test_reset();
        test_rotation();
        test_lock_limit();
        test_sole_lock();
        test_release_idle();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
